// File: rtl/usb_tx_sched.sv
// USB packet scheduler: arbitrates handshake vs. data requests and streams
// PID, payload and CRC16 bytes to usb_tx, enforcing an inter-packet gap.
module usb_tx_sched #(
  parameter int IPG_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hs_req,
  input  logic [3:0] hs_pid,
  output logic       hs_done,
  input  logic       tx_req,
  input  logic [3:0] tx_pid,
  input  logic       tx_zlp,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready
);

  localparam int GW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(IPG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP, S_GAP
  } state_t;

  state_t        r_state;
  logic [GW-1:0] r_gap;
  logic          r_arm;
  logic          r_gnt_hs;
  logic          r_zlp;
  logic [15:0]   r_crc;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_hs_done;
  logic          r_tx_done;
  logic          r_tx_err;

  logic          w_take;
  logic          w_pay;
  logic [15:0]   w_crc_nxt;

  // Reflected CRC16 (0x8005 reversed = 0xA001), one byte LSB-first.
  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++)
      x = x[0] ? ((x >> 1) ^ 16'hA001) : (x >> 1);
    return x;
  endfunction

  assign w_take    = r_valid & ready;
  assign w_pay     = (r_state == S_DATA) & ready & tx_valid;
  assign w_crc_nxt = crc16_upd(r_crc, tx_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_gap     <= '0;
      r_arm     <= 1'b0;
      r_gnt_hs  <= 1'b0;
      r_zlp     <= 1'b0;
      r_crc     <= 16'hFFFF;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_hs_done <= 1'b0;
      r_tx_done <= 1'b0;
      r_tx_err  <= 1'b0;
    end else begin
      // r_arm holds off granting on the first edge after reset release.
      r_arm     <= 1'b1;
      r_hs_done <= 1'b0;
      r_tx_done <= 1'b0;
      r_tx_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_arm && (r_gap == '0) && (hs_req || tx_req)) begin
            r_state  <= S_PID;
            r_valid  <= 1'b1;
            r_crc    <= 16'hFFFF;
            r_gnt_hs <= hs_req;
            r_zlp    <= tx_zlp;
            // PID in the low nibble, check nibble high: goes out LSB-first.
            r_data   <= hs_req ? {~hs_pid, hs_pid} : {~tx_pid, tx_pid};
          end
        end
        S_PID: begin
          if (w_take) begin
            if (r_gnt_hs) begin
              r_state   <= S_EOP;
              r_valid   <= 1'b0;
              r_hs_done <= 1'b1;
            end else if (r_zlp) begin
              r_state <= S_CRC_LO;
              r_data  <= ~r_crc[7:0];
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_take) begin
            if (tx_valid) begin
              r_crc <= w_crc_nxt;
              if (tx_last) begin
                r_state <= S_CRC_LO;
                r_data  <= ~w_crc_nxt[7:0];
              end
            end else begin
              // Underrun: truncate the packet without CRC.
              r_state   <= S_EOP;
              r_valid   <= 1'b0;
              r_tx_done <= 1'b1;
              r_tx_err  <= 1'b1;
            end
          end
        end
        S_CRC_LO: begin
          if (w_take) begin
            r_state <= S_CRC_HI;
            r_data  <= ~r_crc[15:8];
          end
        end
        S_CRC_HI: begin
          if (w_take) begin
            r_state   <= S_EOP;
            r_valid   <= 1'b0;
            r_tx_done <= 1'b1;
          end
        end
        S_EOP: begin
          r_state  <= S_GAP;
          r_gap    <= GAP_LOAD;
          r_gnt_hs <= 1'b0;
          r_data   <= 8'h00;
        end
        S_GAP: begin
          if (r_gap == '0) r_state <= S_IDLE;
          else             r_gap   <= r_gap - GW'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data     = (r_state == S_DATA) ? tx_data : r_data;
  assign valid    = r_valid;
  assign tx_ready = w_pay;
  assign hs_done  = r_hs_done;
  assign tx_done  = r_tx_done;
  assign tx_err   = r_tx_err;

endmodule

// File: tb/tb_usb_tx_sched.sv
// Randomized bench for usb_tx_sched: bytes seen on the usb_tx side are
// compared against packets built from the PID/payload/CRC16 rules.
module tb_usb_tx_sched;
  localparam int IPG = 32;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hs_req = 1'b0, tx_req = 1'b0, tx_zlp = 1'b0;
  logic [3:0] hs_pid = 4'h0, tx_pid = 4'h0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0, tx_last = 1'b0, ready = 1'b0;
  logic       hs_done, tx_done, tx_err, tx_ready, valid;
  logic [7:0] data;

  usb_tx_sched #(.IPG_CYCLES(IPG)) dut (
    .clk(clk), .reset(reset),
    .hs_req(hs_req), .hs_pid(hs_pid), .hs_done(hs_done),
    .tx_req(tx_req), .tx_pid(tx_pid), .tx_zlp(tx_zlp),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err),
    .data(data), .valid(valid), .ready(ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  bq_t cap_q, last_pkt, prev_pkt, pay_q, pay_src;
  int  hs_done_cnt, tx_done_cnt, tx_err_cnt, tx_ready_cnt;
  int  cyc = 0, fall_cyc = 0, last_gap = 0, gap_bad = 0, pulse_bad = 0;
  bit  have_fall = 0, prev_valid = 0, no_last = 0, rdy_rand = 1;

  // Source side: random usb_tx strobe, payload presented from pay_q.
  initial forever begin
    @(posedge clk); #1;
    ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (pay_q.size() > 0) begin
      tx_valid = 1'b1; tx_data = pay_q[0];
      tx_last  = (pay_q.size() == 1) && !no_last;
    end else begin
      tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
    end
  end

  // Sink side: capture accepted bytes, track packet boundaries and pulse rules.
  initial forever begin : mon
    bit fall;
    @(negedge clk);
    cyc++;
    if (!reset) begin
      prev_valid = 0; have_fall = 0; cap_q.delete();
    end else begin
      if (valid && ready) cap_q.push_back(data);
      if (tx_ready) begin
        if (pay_q.size() > 0) void'(pay_q.pop_front());
        tx_ready_cnt++;
        if (!(valid && ready)) pulse_bad++;
      end
      fall = prev_valid && !valid;
      if (fall) begin
        prev_pkt = last_pkt; last_pkt = cap_q; cap_q.delete();
        fall_cyc = cyc; have_fall = 1;
      end
      if (!prev_valid && valid && have_fall) begin
        last_gap = cyc - fall_cyc;
        if (last_gap < IPG) gap_bad++;
      end
      if ((hs_done || tx_done) != fall) pulse_bad++;
      if (tx_err && !tx_done) pulse_bad++;
      if (hs_done && (tx_done || tx_err)) pulse_bad++;
      hs_done_cnt += int'(hs_done);
      tx_done_cnt += int'(tx_done);
      tx_err_cnt  += int'(tx_err);
      prev_valid = valid;
    end
  end

  // Reference packet: PID byte, payload, then ~CRC16 low/high, CRC computed bit-serially.
  function automatic bq_t exp_tx(input logic [3:0] pid, input bq_t p);
    bq_t e;
    logic [15:0] crc;
    logic fb;
    crc = 16'hFFFF;
    e.push_back({~pid, pid});
    foreach (p[i]) begin
      e.push_back(p[i]);
      for (int b = 0; b < 8; b++) begin
        fb  = crc[0] ^ p[i][b];
        crc = crc >> 1;
        if (fb) crc = crc ^ 16'hA001;
      end
    end
    crc = ~crc;
    e.push_back(crc[7:0]);
    e.push_back(crc[15:8]);
    return e;
  endfunction

  task automatic cmp_pkt(input string tag, input bq_t got, input bq_t exp, input bit prefix);
    if (!prefix) chk({tag, "_len"}, got.size(), exp.size());
    foreach (exp[i])
      chk($sformatf("%s_b%0d", tag, i), (i < got.size()) ? {24'h0, got[i]} : 32'hDEAD, {24'h0, exp[i]});
  endtask

  task automatic run(input bit do_hs, input bit do_tx, input logic [3:0] hpid,
                     input logic [3:0] tpid, input bit urun, input string tag);
    bq_t ehs, etx;
    int n, npay;
    npay = pay_src.size();
    ehs.push_back({~hpid, hpid});
    if (urun) begin
      etx.push_back({~tpid, tpid});
      foreach (pay_src[i]) etx.push_back(pay_src[i]);
    end else etx = exp_tx(tpid, pay_src);
    hs_done_cnt = 0; tx_done_cnt = 0; tx_err_cnt = 0; tx_ready_cnt = 0;
    no_last = urun; rdy_rand = !urun;
    if (do_tx) pay_q = pay_src;
    hs_req = do_hs; hs_pid = hpid;
    tx_req = do_tx; tx_pid = tpid; tx_zlp = (npay == 0);
    n = 0;
    while ((hs_req || tx_req) && n < 3000) begin
      tick(); n++;
      if (hs_req && hs_done_cnt > 0) hs_req = 0;
      if (tx_req && tx_done_cnt > 0) tx_req = 0;
    end
    chk({tag, "_finished"}, n < 3000, 1);
    hs_req = 0; tx_req = 0;
    repeat (3) tick();
    if (do_hs && do_tx) begin
      cmp_pkt({tag, "_hs"}, prev_pkt, ehs, 0);
      cmp_pkt({tag, "_tx"}, last_pkt, etx, 0);
      chk({tag, "_gap_ge_ipg"}, last_gap >= IPG, 1);
    end else if (do_hs) cmp_pkt({tag, "_hs"}, last_pkt, ehs, 0);
    else cmp_pkt({tag, "_tx"}, last_pkt, etx, urun);
    if (urun) chk({tag, "_no_crc"}, last_pkt.size() <= npay + 2, 1);
    chk({tag, "_hs_done_n"}, hs_done_cnt, do_hs);
    chk({tag, "_tx_done_n"}, tx_done_cnt, do_tx);
    chk({tag, "_tx_err_n"}, tx_err_cnt, urun);
    if (do_tx) chk({tag, "_tx_ready_n"}, tx_ready_cnt, npay);
    pay_q.delete(); no_last = 0; rdy_rand = 1;
  endtask

  logic [3:0] hs_pids[3] = '{4'h2, 4'hA, 4'hE};
  logic [3:0] tx_pids[2] = '{4'h3, 4'hB};

  initial begin
    int n, t;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_hs_done", hs_done, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_tx_err", tx_err, 0);
    chk("rst_data", data, 8'h00);
    reset = 1'b1; hs_req = 1; hs_pid = 4'h2;
    tick();
    chk("no_grant_first_edge", valid, 0);
    hs_req = 0;
    repeat (2) tick();
    chk("idle_after_drop", valid, 0);

    pay_src = {};
    run(1, 0, 4'h2, 4'h0, 0, "ack");
    chk("ack_byte_d2", last_pkt.size() > 0 ? {24'h0, last_pkt[0]} : 32'hDEAD, 32'hD2);
    pay_src = {};
    run(0, 1, 4'h0, 4'h3, 0, "zlp");
    pay_src = '{8'h00, 8'h01, 8'h02, 8'h03};
    run(0, 1, 4'h0, 4'hB, 0, "data1_4");
    pay_src = '{8'($urandom), 8'($urandom), 8'($urandom)};
    run(1, 1, 4'h2, 4'h3, 0, "both");
    pay_src = '{8'h5A, 8'hA5};
    run(0, 1, 4'h0, 4'h3, 1, "urun");

    // Reset in the middle of a payload.
    pay_src = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    pay_q = pay_src; rdy_rand = 0; tx_done_cnt = 0;
    tx_req = 1; tx_pid = 4'h3; tx_zlp = 0;
    n = 0;
    while (cap_q.size() < 3 && n < 200) begin tick(); n++; end
    chk("mid_reached_data", n < 200, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_tx_ready", tx_ready, 0);
    chk("mid_rst_data", data, 8'h00);
    tx_req = 0; pay_q.delete(); rdy_rand = 1;
    repeat (3) tick();
    chk("mid_rst_no_done", tx_done_cnt, 0);
    reset = 1'b1;
    repeat (2) tick();
    pay_src = {};
    run(1, 0, 4'h2, 4'h0, 0, "post_rst_ack");

    for (int k = 0; k < 20; k++) begin
      t = $urandom_range(0, 2);
      pay_src = {};
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) pay_src.push_back(8'($urandom));
      run(t != 1, t != 0, hs_pids[$urandom_range(0, 2)], tx_pids[$urandom_range(0, 1)],
          0, $sformatf("rnd%0d", k));
    end

    chk("ipg_gaps_bad", gap_bad, 0);
    chk("pulse_rules_bad", pulse_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
